// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port between writeback (absolute priority) and a DEPTH-entry in-order MD result queue.
// MD results write no earlier than the cycle after acceptance; md_ready drops when the queue is full, and WB is never stalled.
module grf_wport_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_addr,
    input  logic [DW-1:0]          wb_data,
    input  logic [31:0]            wb_pc,

    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [AW-1:0]          md_addr,
    input  logic [DW-1:0]          md_data,
    input  logic [31:0]            md_pc,

    output logic                   grf_we,
    output logic [AW-1:0]          grf_addr,
    output logic [DW-1:0]          grf_data,
    output logic [31:0]            grf_pc,

    input  logic [AW-1:0]          chk_addr1,
    input  logic [AW-1:0]          chk_addr2,
    output logic                   chk_hit1,
    output logic                   chk_hit2,

    output logic                   md_full,
    output logic [$clog2(DEPTH):0] md_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    q_addr [DEPTH];
    logic [DW-1:0]    q_data [DEPTH];
    logic [31:0]      q_pc   [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic wb_req;
    logic q_empty;
    logic q_full;
    logic push;
    logic pop;
    logic hit1;
    logic hit2;

    assign wb_req  = wb_we && (wb_addr != '0);
    assign q_empty = (count == '0);
    assign q_full  = (count == FULL_CNT);

    // No pass-through when full: a same-cycle pop does not open a slot for MD.
    assign md_ready = !reset && !q_full;
    assign push     = md_valid && md_ready && (md_addr != '0);
    assign pop      = !reset && !wb_req && !q_empty;

    assign grf_we   = !reset && (wb_req || (!q_empty && q_valid[head]));
    assign grf_addr = wb_req ? wb_addr : q_addr[head];
    assign grf_data = wb_req ? wb_data : q_data[head];
    assign grf_pc   = wb_req ? wb_pc   : q_pc[head];

    assign md_full  = !reset && q_full;
    assign md_count = count;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i] == chk_addr1)) hit1 = 1'b1;
            if (q_valid[i] && (q_addr[i] == chk_addr2)) hit2 = 1'b1;
        end
    end

    assign chk_hit1 = !reset && (chk_addr1 != '0) && hit1;
    assign chk_hit2 = !reset && (chk_addr2 != '0) && hit2;

    // Squashed entries keep their slot so ordering and count stay simple;
    // the incoming MD entry is written after the squash and so survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_req && q_valid[i] && (q_addr[i] == wb_addr)) q_valid[i] <= 1'b0;
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (push) begin
                q_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= md_addr;
            q_data[tail] <= md_data;
            q_pc[tail]   <= md_pc;
        end
    end

endmodule
